// File: rtl/timer_scheduler.sv
// Shared down-counting timer with round-robin arbitration between NREQ
// requesters. A granted requester holds its REQ bit while the timer counts
// its LEN down to zero. When the count expires, DONE pulses for one cycle.
// A RELEASE cycle always follows a grant, so two grants are never back to back.
module timer_scheduler #(
   parameter int NREQ = 4,
   parameter int W    = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ*W-1:0] LEN,
   output logic [NREQ-1:0]   GNT,
   output logic [NREQ-1:0]   DONE,
   output logic              BUSY,
   output logic [W-1:0]      COUNT
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRE  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    count_q, count_d;
   logic [NREQ-1:0] gnt_q,   gnt_d;
   logic [NREQ-1:0] done_q,  done_d;
   logic [IW-1:0]   last_q,  last_d;   // index of the most recent grant

   logic            found;
   logic [IW-1:0]   win;
   logic [IW-1:0]   cand;
   logic [W-1:0]    win_len;

   // Round-robin search: first active request at or above last_q+1, wrapping around.
   always_comb begin
      // NOTE: every signal gets a default before the conditional logic, so no
      // path leaves it unassigned and no latch is inferred.
      found = 1'b0;
      win   = last_q;
      cand  = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = IW'((int'(last_q) + off) % NREQ);
         if (!found && REQ[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Select the delay belonging to the arbitration winner.
   always_comb begin
      win_len = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) win_len = LEN[i*W +: W];
      end
   end

   // Next-state logic. LEN is sampled only at grant time. Other REQ bits are
   // looked at only in IDLE. An abort (granted REQ dropped) wins over expiry.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = RUN;
               count_d    = win_len;
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               last_d     = win;
            end
         end
         RUN: begin
            if (!REQ[last_q]) begin
               state_d = RELEASE;
               gnt_d   = '0;
            end else if (count_q == '0) begin
               state_d = EXPIRE;
               done_d  = gnt_q;
            end else begin
               count_d = count_q - W'(1);
            end
         end
         EXPIRE: begin
            state_d = RELEASE;
            gnt_d   = '0;
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State register with synchronous reset. LAST resets to NREQ-1 so that
   // requester 0 wins the first arbitration.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before this edge.
      if (RESET) begin
         state_q <= IDLE;
         count_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         last_q  <= IW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         last_q  <= last_d;
      end
   end

   assign GNT   = gnt_q;
   assign DONE  = done_q;
   assign COUNT = count_q;
   assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler (NREQ=4, W=8). The stimulus process
// queues the grant order and the DONE latencies it expects. The monitor pops
// these at each new grant and at each DONE pulse and compares them.
module tb_timer_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 8;

   typedef struct {
      logic [NREQ-1:0] done;
      int              lat;    // cycles from first GNT cycle to DONE cycle
   } done_exp_t;

   logic              CLK;
   logic              RESET;
   logic [NREQ-1:0]   REQ;
   logic [NREQ*W-1:0] LEN;
   logic [NREQ-1:0]   GNT;
   logic [NREQ-1:0]   DONE;
   logic              BUSY;
   logic [W-1:0]      COUNT;

   logic [NREQ-1:0]   exp_gnt[$];
   done_exp_t         exp_done[$];

   int n_checks = 0;
   int n_fail   = 0;

   timer_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .REQ   (REQ),
      .LEN   (LEN),
      .GNT   (GNT),
      .DONE  (DONE),
      .BUSY  (BUSY),
      .COUNT (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; outputs are settled by then.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic ctl(input string tag, input logic [NREQ-1:0] g,
                      input logic [NREQ-1:0] d, input logic b);
      check({tag, ".gnt"},  32'(GNT),  32'(g));
      check({tag, ".done"}, 32'(DONE), 32'(d));
      check({tag, ".busy"}, 32'(BUSY), 32'(b));
   endtask

   task automatic set_len(input int i, input logic [W-1:0] v);
      LEN[i*W +: W] = v;
   endtask

   task automatic push(input logic [NREQ-1:0] g, input int lat);
      done_exp_t e;
      exp_gnt.push_back(g);
      if (lat >= 0) begin
         e.done = g;
         e.lat  = lat;
         exp_done.push_back(e);
      end
   endtask

   // Monitor: compares each new grant and each DONE pulse against the queues.
   logic [NREQ-1:0] prev_gnt = '0;
   int              since    = 0;
   initial begin
      logic [NREQ-1:0] eg;
      done_exp_t       ed;
      forever begin
         @(negedge CLK);
         since++;
         if (GNT != '0 && GNT != prev_gnt) begin
            since = 0;
            if (exp_gnt.size() == 0) check("unexpected_grant", 32'(GNT), 32'd0);
            else begin
               eg = exp_gnt.pop_front();
               check("grant_order", 32'(GNT), 32'(eg));
            end
         end
         if (DONE != '0) begin
            if (exp_done.size() == 0) check("unexpected_done", 32'(DONE), 32'd0);
            else begin
               ed = exp_done.pop_front();
               check("done_value", 32'(DONE), 32'(ed.done));
               check("done_latency", 32'(since), 32'(ed.lat));
            end
         end
         prev_gnt = GNT;
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      RESET = 1'b1;
      REQ   = '0;
      LEN   = '0;
      step();
      step();
      ctl("reset", 4'b0000, 4'b0000, 1'b0);
      check("reset.count", 32'(COUNT), 32'd0);
      RESET = 1'b0;

      // Single request, LEN=3: four RUN cycles, then EXPIRE, RELEASE, IDLE.
      set_len(0, 8'd3);
      REQ = 4'b0001;
      push(4'b0001, 4);
      for (int n = 0; n < 4; n++) begin
         step();
         ctl("single.run", 4'b0001, 4'b0000, 1'b1);
         check("single.count", 32'(COUNT), 32'(3 - n));
      end
      step();
      ctl("single.expire", 4'b0001, 4'b0001, 1'b1);
      check("single.expire_count", 32'(COUNT), 32'd0);
      REQ = 4'b0000;
      step();
      ctl("single.release", 4'b0000, 4'b0000, 1'b1);
      step();
      ctl("single.idle", 4'b0000, 4'b0000, 1'b0);

      // Round-robin from reset with all LEN=0: grant order 0,1,2,3,0.
      RESET = 1'b1;
      step();
      step();
      RESET = 1'b0;
      LEN = '0;
      REQ = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         logic [NREQ-1:0] oh;
         oh = 4'b0001 << (g % 4);
         push(oh, 1);
         step();
         ctl("rr.run", oh, 4'b0000, 1'b1);
         step();
         ctl("rr.expire", oh, oh, 1'b1);
         if (g == 4) REQ = 4'b0000;
         step();
         ctl("rr.release", 4'b0000, 4'b0000, 1'b1);
         step();
         ctl("rr.idle", 4'b0000, 4'b0000, 1'b0);
      end

      // Abort: drop REQ[2] after three RUN cycles. GNT falls at once, no DONE.
      set_len(2, 8'd10);
      REQ = 4'b0100;
      push(4'b0100, -1);
      for (int n = 0; n < 3; n++) begin
         step();
         ctl("abort.run", 4'b0100, 4'b0000, 1'b1);
         check("abort.count", 32'(COUNT), 32'(10 - n));
      end
      REQ = 4'b0000;
      step();
      ctl("abort.release", 4'b0000, 4'b0000, 1'b1);
      step();
      ctl("abort.idle", 4'b0000, 4'b0000, 1'b0);
      step();
      ctl("abort.idle2", 4'b0000, 4'b0000, 1'b0);

      // Reset mid-run at COUNT=12. Afterwards requester 0 beats requester 3.
      set_len(1, 8'd20);
      REQ = 4'b0010;
      push(4'b0010, -1);
      step();
      ctl("midrst.run", 4'b0010, 4'b0000, 1'b1);
      check("midrst.count", 32'(COUNT), 32'd20);
      for (int n = 1; n <= 8; n++) begin
         step();
         check("midrst.count", 32'(COUNT), 32'(20 - n));
      end
      RESET = 1'b1;
      REQ   = 4'b0000;
      step();
      ctl("midrst.after", 4'b0000, 4'b0000, 1'b0);
      check("midrst.after_count", 32'(COUNT), 32'd0);
      RESET = 1'b0;
      REQ   = 4'b1001;
      set_len(0, 8'd2);
      push(4'b0001, 3);
      for (int n = 0; n < 3; n++) begin
         step();
         ctl("postrst.run", 4'b0001, 4'b0000, 1'b1);
         check("postrst.count", 32'(COUNT), 32'(2 - n));
      end
      step();
      ctl("postrst.expire", 4'b0001, 4'b0001, 1'b1);
      REQ = 4'b0000;
      step();
      ctl("postrst.release", 4'b0000, 4'b0000, 1'b1);
      step();
      ctl("postrst.idle", 4'b0000, 4'b0000, 1'b0);

      // LEN=255 on requester 3: full count with no wrap, DONE 256 cycles after grant.
      set_len(3, 8'd255);
      REQ = 4'b1000;
      push(4'b1000, 256);
      step();
      ctl("max.run", 4'b1000, 4'b0000, 1'b1);
      check("max.count", 32'(COUNT), 32'd255);
      for (int n = 1; n <= 255; n++) begin
         step();
         check("max.count", 32'(COUNT), 32'(255 - n));
      end
      step();
      ctl("max.expire", 4'b1000, 4'b1000, 1'b1);
      check("max.expire_count", 32'(COUNT), 32'd0);
      REQ = 4'b0000;
      step();
      ctl("max.release", 4'b0000, 4'b0000, 1'b1);
      step();
      ctl("max.idle", 4'b0000, 4'b0000, 1'b0);

      // LEN[0] changes 5->1 after the grant and has no effect (6 RUN cycles).
      // REQ[1] rises mid-run and is served only after the current grant ends.
      set_len(0, 8'd5);
      set_len(1, 8'd0);
      REQ = 4'b0001;
      push(4'b0001, 6);
      step();
      ctl("lenchg.run", 4'b0001, 4'b0000, 1'b1);
      check("lenchg.count", 32'(COUNT), 32'd5);
      set_len(0, 8'd1);
      REQ = 4'b0011;
      push(4'b0010, 1);
      for (int n = 1; n <= 5; n++) begin
         step();
         ctl("lenchg.run", 4'b0001, 4'b0000, 1'b1);
         check("lenchg.count", 32'(COUNT), 32'(5 - n));
      end
      step();
      ctl("lenchg.expire", 4'b0001, 4'b0001, 1'b1);
      REQ = 4'b0010;
      step();
      ctl("lenchg.release", 4'b0000, 4'b0000, 1'b1);
      step();
      ctl("lenchg.idle", 4'b0000, 4'b0000, 1'b0);
      step();
      ctl("next.run", 4'b0010, 4'b0000, 1'b1);
      check("next.count", 32'(COUNT), 32'd0);
      step();
      ctl("next.expire", 4'b0010, 4'b0010, 1'b1);
      REQ = 4'b0000;
      step();
      ctl("next.release", 4'b0000, 4'b0000, 1'b1);
      step();
      ctl("next.idle", 4'b0000, 4'b0000, 1'b0);

      step();
      step();
      check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
      check("done_queue_drained", 32'(exp_done.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the timer (2..8).
REQ-002 Parameter W, default 8, width of each requested delay and of the down-counter.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 REQ  input  NREQ  per-requester timing request, level-sensitive; bit i = requester i.
REQ-006 LEN  input  NREQ*W  per-requester delay; requester i uses bits [i*W +: W].
REQ-007 GNT  output  NREQ  one-hot grant; at most one bit high.
REQ-008 DONE  output  NREQ  one-hot, single-cycle pulse marking expiry for the granted requester.
REQ-009 BUSY  output  1  high whenever the state is not IDLE.
REQ-010 COUNT  output  W  current down-counter value.

Function
REQ-011 The block SHALL implement four states: IDLE, RUN, EXPIRE, RELEASE.
REQ-012 IDLE: no REQ bit high -> stay IDLE; any REQ bit high -> select winner i, load COUNT <= LEN[i], set GNT <= one-hot(i), go RUN.
REQ-013 Winner selection SHALL be round-robin: the first high REQ bit searching upward from (LAST+1) mod NREQ, where LAST is the index last granted.
REQ-014 LAST SHALL update to i at the edge that issues the grant.
REQ-015 RUN, REQ[i] still high: COUNT != 0 -> COUNT <= COUNT-1, stay RUN; COUNT == 0 -> go EXPIRE.
REQ-016 RUN, REQ[i] low (abort): go RELEASE immediately; no DONE pulse is issued; the abort takes priority over COUNT == 0.
REQ-017 EXPIRE SHALL last exactly one cycle, with DONE[i] = 1 and GNT[i] = 1, then go RELEASE.
REQ-018 RELEASE SHALL last exactly one cycle, with GNT = 0 and DONE = 0, then go IDLE.
REQ-019 Guaranteed gap: at least two cycles between the last GNT cycle of one grant and the first GNT cycle of the next.
REQ-020 Latency: REQ high in IDLE at edge k -> GNT high from edge k; with LEN = L and no abort, DONE is high in cycle k+L+1 (the RUN state holds L+1 cycles).
REQ-021 LEN = 0 SHALL give one RUN cycle followed by EXPIRE.
REQ-022 LEN = 2^W-1 SHALL count fully, with no wrap; COUNT never decrements below 0.
REQ-023 LEN SHALL be sampled only at grant; changes to LEN during RUN SHALL have no effect.
REQ-024 REQ changes on non-granted bits during RUN, EXPIRE or RELEASE SHALL be ignored until IDLE.
REQ-025 GNT SHALL be high only in RUN and EXPIRE; DONE SHALL be high only in EXPIRE; BUSY = (state != IDLE).
REQ-026 All outputs SHALL be registered or decoded from state only; there is no combinational path from REQ or LEN to any output.

Reset
REQ-027 When RESET = 1 at a posedge: state <= IDLE, COUNT <= 0, GNT <= 0, DONE <= 0, LAST <= NREQ-1 (so requester 0 wins the first arbitration).
REQ-028 Reset SHALL override every state, including mid-RUN and EXPIRE; any pending DONE SHALL be discarded.
REQ-029 The first arbitration may occur on the first edge with RESET = 0.

Verification
REQ-030 Single request: NREQ = 4, W = 8, REQ = 0001, LEN[0] = 3 -> GNT = 0001 for 5 cycles (4 RUN + 1 EXPIRE), COUNT 3,2,1,0; DONE = 0001 for exactly 1 cycle, aligned with the last GNT cycle; then BUSY low after RELEASE.
REQ-031 Round-robin: REQ = 1111 held, all LEN = 0 -> grant order 0,1,2,3,0; each grant is 2 GNT cycles with a 2-cycle gap between grants.
REQ-032 Abort: REQ = 0100, LEN[2] = 10; drop REQ[2] after 3 RUN cycles -> GNT falls at the next edge, DONE never asserts, RELEASE then IDLE.
REQ-033 Reset mid-run: LEN[1] = 20; assert RESET at COUNT = 12 -> next cycle state IDLE, COUNT = 0, GNT = 0, DONE = 0; after release, a request on bit 3 with bit 0 also high -> bit 0 granted.
REQ-034 Boundary: LEN = 255 -> DONE occurs exactly 256 cycles after grant, and COUNT never wraps.
REQ-035 LEN change: change LEN[0] from 5 to 1 one cycle after grant -> expiry still occurs after 6 RUN cycles.
